// File: rtl/cv32e40p_alu_tmr_fault_mgr.sv
// -----------------------------------------------------------------------------
// cv32e40p_alu_tmr_fault_mgr
//
// Fault manager for the triplicated ALU. It watches the per-slot mismatch flags
// from the majority voters and keeps a leaky error counter for each slot. The
// first slot that reaches THRESH errors is declared permanently faulted, and the
// spare ALU is switched into that slot. A second permanent fault, or any vote
// without a majority, locks the block in DEGRADED until clear_i or reset.
//
// Ports
//   clk              clock
//   rst_n            asynchronous active-low reset
//   sample_i         mismatch_i is valid this cycle
//   mismatch_i[2:0]  bit i: slot i disagreed with the voted result
//   clear_i          synchronous re-arm, identical in effect to reset
//   spare_en_o[2:0]  one-hot spare routing into voter slot i
//   faulted_o[2:0]   sticky per-slot permanent-fault flags
//   state_o[1:0]     0 NORMAL, 1 SPARE, 2 DEGRADED
//   fatal_o          high while in DEGRADED
//   uncorrectable_o  one-cycle pulse for a sample with two or more mismatches
//   event_cnt_o      saturating count of mismatching samples
//
// state    | meaning
// ---------+--------------------------------------------------------------
// NORMAL   | all three original replicas in use, no permanent fault yet
// SPARE    | one slot faulted, spare ALU routed into it
// DEGRADED | second permanent fault or no-majority vote; frozen until clear
// -----------------------------------------------------------------------------
module cv32e40p_alu_tmr_fault_mgr #(
    parameter int THRESH      = 2,
    parameter int CNT_W       = 4,
    parameter int LEAK_PERIOD = 1024,
    parameter int LEAK_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_i,
    input  logic [2:0]  mismatch_i,
    input  logic        clear_i,
    output logic [2:0]  spare_en_o,
    output logic [2:0]  faulted_o,
    output logic [1:0]  state_o,
    output logic        fatal_o,
    output logic        uncorrectable_o,
    output logic [15:0] event_cnt_o
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_SPARE    = 2'd1,
        ST_DEGRADED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(THRESH);
    localparam logic [LEAK_W-1:0] LEAK_C   = LEAK_W'(LEAK_PERIOD);

    state_t             state;
    logic [CNT_W-1:0]   cnt [3];
    logic [LEAK_W-1:0]  leak_cnt;
    logic [2:0]         spare_en;
    logic [2:0]         faulted;
    logic               fatal;
    logic               uncorrectable;
    logic [15:0]        event_cnt;

    logic [1:0]         n_mis;
    logic               single_s;
    logic               multi_s;
    logic               clean_s;
    logic [1:0]         idx;
    logic [CNT_W-1:0]   cnt_inc;
    logic               thresh_hit;
    logic               leak_hit;

    always_comb begin
        n_mis      = {1'b0, mismatch_i[0]} + {1'b0, mismatch_i[1]} + {1'b0, mismatch_i[2]};
        single_s   = sample_i && (n_mis == 2'd1);
        multi_s    = sample_i && (n_mis >= 2'd2);
        clean_s    = sample_i && (n_mis == 2'd0);
        // Index is only meaningful when exactly one bit is set.
        idx        = mismatch_i[2] ? 2'd2 : (mismatch_i[1] ? 2'd1 : 2'd0);
        cnt_inc    = (cnt[idx] >= THRESH_C) ? THRESH_C : cnt[idx] + CNT_W'(1);
        thresh_hit = single_s && (cnt_inc == THRESH_C);
        leak_hit   = (LEAK_PERIOD != 0) && ((leak_cnt + LEAK_W'(1)) == LEAK_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_NORMAL;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
            leak_cnt      <= '0;
            spare_en      <= '0;
            faulted       <= '0;
            fatal         <= 1'b0;
            uncorrectable <= 1'b0;
            event_cnt     <= '0;
        end else if (clear_i) begin
            state         <= ST_NORMAL;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
            leak_cnt      <= '0;
            spare_en      <= '0;
            faulted       <= '0;
            fatal         <= 1'b0;
            uncorrectable <= 1'b0;
            event_cnt     <= '0;
        end else begin
            uncorrectable <= multi_s;
            if (sample_i && (n_mis != 2'd0) && (event_cnt != 16'hFFFF))
                event_cnt <= event_cnt + 16'd1;

            case (state)
                ST_NORMAL, ST_SPARE: begin
                    if (multi_s) begin
                        leak_cnt <= '0;
                        state    <= ST_DEGRADED;
                        fatal    <= 1'b1;
                    end else if (single_s) begin
                        leak_cnt <= '0;
                        if (thresh_hit) begin
                            faulted[idx] <= 1'b1;
                            if (state == ST_NORMAL) begin
                                // Slot now tracks the spare, so it starts from a clean count.
                                spare_en <= 3'b001 << idx;
                                cnt[idx] <= '0;
                                state    <= ST_SPARE;
                            end else begin
                                cnt[idx] <= cnt_inc;
                                state    <= ST_DEGRADED;
                                fatal    <= 1'b1;
                            end
                        end else begin
                            cnt[idx] <= cnt_inc;
                        end
                    end else if (clean_s) begin
                        if (LEAK_PERIOD == 0) begin
                            leak_cnt <= '0;
                        end else if (leak_hit) begin
                            leak_cnt <= '0;
                            for (int k = 0; k < 3; k++) begin
                                if (!faulted[k] && (cnt[k] != '0))
                                    cnt[k] <= cnt[k] - CNT_W'(1);
                            end
                        end else begin
                            leak_cnt <= leak_cnt + LEAK_W'(1);
                        end
                    end
                end
                ST_DEGRADED: begin
                end
                default: begin
                    state <= ST_DEGRADED;
                    fatal <= 1'b1;
                end
            endcase
        end
    end

    assign spare_en_o      = spare_en;
    assign faulted_o       = faulted;
    assign state_o         = state;
    assign fatal_o         = fatal;
    assign uncorrectable_o = uncorrectable;
    assign event_cnt_o     = event_cnt;

endmodule

// File: tb/tb_cv32e40p_alu_tmr_fault_mgr.sv
// Scoreboard bench for cv32e40p_alu_tmr_fault_mgr with THRESH=2, LEAK_PERIOD=4.
module tb_cv32e40p_alu_tmr_fault_mgr;

    localparam int THRESH      = 2;
    localparam int CNT_W       = 4;
    localparam int LEAK_PERIOD = 4;
    localparam int LEAK_W      = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_i = 1'b0;
    logic [2:0]  mismatch_i = 3'b000;
    logic        clear_i = 1'b0;
    logic [2:0]  spare_en_o;
    logic [2:0]  faulted_o;
    logic [1:0]  state_o;
    logic        fatal_o;
    logic        uncorrectable_o;
    logic [15:0] event_cnt_o;

    cv32e40p_alu_tmr_fault_mgr #(
        .THRESH(THRESH), .CNT_W(CNT_W), .LEAK_PERIOD(LEAK_PERIOD), .LEAK_W(LEAK_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .mismatch_i(mismatch_i),
        .clear_i(clear_i), .spare_en_o(spare_en_o), .faulted_o(faulted_o),
        .state_o(state_o), .fatal_o(fatal_o), .uncorrectable_o(uncorrectable_o),
        .event_cnt_o(event_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int spare;
        int faulted;
        int state;
        int fatal;
        int unc;
        int evt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: mode 0 normal, 1 spare, 2 degraded.
    int m_mode;
    int m_cnt[3];
    int m_leak;
    int m_spare;
    int m_faulted;
    int m_unc;
    int m_evt;

    function automatic void model_reset();
        m_mode = 0; m_leak = 0; m_spare = 0; m_faulted = 0; m_unc = 0; m_evt = 0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    endfunction

    function automatic void model_step(bit s, logic [2:0] m, bit c);
        int ones;
        int slot;
        if (c) begin
            model_reset();
            return;
        end
        m_unc = 0;
        if (!s) return;
        ones = $countones(m);
        slot = m[0] ? 0 : (m[1] ? 1 : 2);
        if (ones > 0 && m_evt < 65535) m_evt++;
        if (ones >= 2) begin
            m_unc = 1;
            if (m_mode != 2) begin
                m_leak = 0;
                m_mode = 2;
            end
        end else if (m_mode != 2) begin
            if (ones == 1) begin
                m_leak = 0;
                if (m_cnt[slot] < THRESH) m_cnt[slot]++;
                if (m_cnt[slot] == THRESH) begin
                    m_faulted |= (1 << slot);
                    if (m_mode == 0) begin
                        m_spare = 1 << slot;
                        m_cnt[slot] = 0;
                        m_mode = 1;
                    end else begin
                        m_mode = 2;
                    end
                end
            end else if (LEAK_PERIOD != 0) begin
                if (m_leak + 1 == LEAK_PERIOD) begin
                    m_leak = 0;
                    for (int k = 0; k < 3; k++)
                        if (((m_faulted >> k) & 1) == 0 && m_cnt[k] > 0) m_cnt[k]--;
                end else begin
                    m_leak++;
                end
            end
        end
    endfunction

    function automatic void check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic step(bit s, logic [2:0] m, bit c);
        exp_t e;
        sample_i   = s;
        mismatch_i = m;
        clear_i    = c;
        @(posedge clk);
        model_step(s, m, c);
        e.spare = m_spare; e.faulted = m_faulted; e.state = m_mode;
        e.fatal = (m_mode == 2) ? 1 : 0; e.unc = m_unc; e.evt = m_evt;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares the registered outputs half a cycle after each edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("spare_en",      int'(spare_en_o),      e.spare);
                check("faulted",       int'(faulted_o),       e.faulted);
                check("state",         int'(state_o),         e.state);
                check("fatal",         int'(fatal_o),         e.fatal);
                check("uncorrectable", int'(uncorrectable_o), e.unc);
                check("event_cnt",     int'(event_cnt_o),     e.evt);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(string tag);
        check({tag, "_spare"},   int'(spare_en_o),      0);
        check({tag, "_faulted"}, int'(faulted_o),       0);
        check({tag, "_state"},   int'(state_o),         0);
        check({tag, "_fatal"},   int'(fatal_o),         0);
        check({tag, "_unc"},     int'(uncorrectable_o), 0);
        check({tag, "_evt"},     int'(event_cnt_o),     0);
    endtask

    initial begin
        logic [2:0] m;
        int r;
        model_reset();
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Clean samples after reset.
        repeat (5) step(1, 3'b000, 0);
        @(negedge clk);
        check_all_zero("clean5");

        // Slot 1 faults and the spare is swapped in; the spare's count restarts.
        step(0, 3'b000, 1);
        step(1, 3'b010, 0);
        step(1, 3'b010, 0);
        @(negedge clk);
        check("swap_state", int'(state_o), 1);
        check("swap_spare", int'(spare_en_o), 3'b010);
        check("swap_faulted", int'(faulted_o), 3'b010);
        check("swap_evt", int'(event_cnt_o), 2);
        step(1, 3'b010, 0);
        @(negedge clk);
        check("spare_cnt1_state", int'(state_o), 1);
        step(1, 3'b010, 0);
        @(negedge clk);
        check("spare_fault_state", int'(state_o), 2);
        check("spare_fault_fatal", int'(fatal_o), 1);
        check("spare_fault_faulted", int'(faulted_o), 3'b010);
        check("spare_fault_spare", int'(spare_en_o), 3'b010);

        // Leak: four clean samples erase one error, three do not.
        step(0, 3'b000, 1);
        step(1, 3'b001, 0);
        repeat (4) step(1, 3'b000, 0);
        step(1, 3'b001, 0);
        @(negedge clk);
        check("leak4_state", int'(state_o), 0);
        step(0, 3'b000, 1);
        step(1, 3'b001, 0);
        repeat (3) step(1, 3'b000, 0);
        step(1, 3'b001, 0);
        @(negedge clk);
        check("leak3_state", int'(state_o), 1);
        check("leak3_spare", int'(spare_en_o), 3'b001);

        // No-majority vote.
        step(0, 3'b000, 1);
        step(1, 3'b110, 0);
        @(negedge clk);
        check("multi_unc", int'(uncorrectable_o), 1);
        check("multi_state", int'(state_o), 2);
        check("multi_fatal", int'(fatal_o), 1);
        check("multi_evt", int'(event_cnt_o), 1);
        step(0, 3'b000, 0);
        @(negedge clk);
        check("multi_unc_pulse", int'(uncorrectable_o), 0);

        // clear_i wins over a simultaneous sample.
        step(0, 3'b000, 1);
        step(1, 3'b100, 0);
        step(1, 3'b100, 0);
        @(negedge clk);
        check("spare100", int'(spare_en_o), 3'b100);
        step(1, 3'b001, 1);
        @(negedge clk);
        check_all_zero("clear_prio");
        // cnt[0] back to zero: one more 001 must not fault slot 0.
        step(1, 3'b001, 0);
        @(negedge clk);
        check("clear_cnt0_state", int'(state_o), 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) m = 3'b000;
            else if (r < 92) m = 3'b001 << $urandom_range(0, 2);
            else begin
                case ($urandom_range(0, 3))
                    0: m = 3'b011;
                    1: m = 3'b101;
                    2: m = 3'b110;
                    default: m = 3'b111;
                endcase
            end
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, m,
                 ($urandom_range(0, 99) < ((m_mode == 2) ? 10 : 2)) ? 1'b1 : 1'b0);
        end

        // Saturating event counter in DEGRADED, then async reset mid-burst.
        step(0, 3'b000, 1);
        step(1, 3'b011, 0);
        for (int i = 0; i < 70000; i++)
            step(1, 3'b001 << $urandom_range(0, 2), 0);
        @(negedge clk);
        check("evt_sat", int'(event_cnt_o), 16'hFFFF);
        check("evt_sat_state", int'(state_o), 2);
        step(1, 3'b101, 0);
        step(1, 3'b010, 0);
        sample_i = 1'b1;
        mismatch_i = 3'b100;
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3'b100, 0);
        step(0, 3'b000, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
